// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffer pipeline stage (MAIN head register + SKID register), all outputs registered.
// Optional macro PIPE_STAGE_REG_STALL_CNT_EN adds a saturating 16-bit stall counter port.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic                r_inReady;
    logic                r_outValid;
    logic [1:0]          r_occupancy;
    logic [DATA_W-1:0]   r_mainData;
    logic [CTRL_W-1:0]   r_mainCtrl;
    logic [DATA_W-1:0]   r_skidData;
    logic [CTRL_W-1:0]   r_skidCtrl;
    logic [DATA_W-1:0]   w_mainDataNext;
    logic [CTRL_W-1:0]   w_mainCtrlNext;
    logic [DATA_W-1:0]   w_skidDataNext;
    logic [CTRL_W-1:0]   w_skidCtrlNext;
    logic                w_push;
    logic                w_pop;

    assign w_push = in_valid & r_inReady;
    assign w_pop  = r_outValid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (flush) begin
            w_nextState = EMPTY;
        end else begin
            case (r_state)
                EMPTY:   if (w_push) w_nextState = ONE;
                ONE: begin
                    if (w_push && !w_pop)      w_nextState = FULL;
                    else if (!w_push && w_pop) w_nextState = EMPTY;
                end
                FULL:    if (w_pop) w_nextState = ONE;
                default: w_nextState = EMPTY;
            endcase
        end
    end

    // Payload steering; MAIN is zeroed when it empties so out_ctrl reads 0 whenever out_valid is low.
    always_comb begin
        w_mainDataNext = r_mainData;
        w_mainCtrlNext = r_mainCtrl;
        w_skidDataNext = r_skidData;
        w_skidCtrlNext = r_skidCtrl;
        if (flush) begin
            w_mainDataNext = '0;
            w_mainCtrlNext = '0;
            w_skidDataNext = '0;
            w_skidCtrlNext = '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        w_mainDataNext = in_data;
                        w_mainCtrlNext = in_ctrl;
                    end
                end
                ONE: begin
                    if (w_push && w_pop) begin
                        w_mainDataNext = in_data;
                        w_mainCtrlNext = in_ctrl;
                    end else if (w_push) begin
                        w_skidDataNext = in_data;
                        w_skidCtrlNext = in_ctrl;
                    end else if (w_pop) begin
                        w_mainDataNext = '0;
                        w_mainCtrlNext = '0;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        w_mainDataNext = r_skidData;
                        w_mainCtrlNext = r_skidCtrl;
                        w_skidDataNext = '0;
                        w_skidCtrlNext = '0;
                    end
                end
                default: begin
                    w_mainDataNext = '0;
                    w_mainCtrlNext = '0;
                    w_skidDataNext = '0;
                    w_skidCtrlNext = '0;
                end
            endcase
        end
    end

    // Status outputs are registered from the next state so no output has a combinational path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inReady   <= 1'b1;
            r_outValid  <= 1'b0;
            r_occupancy <= 2'd0;
            r_mainData  <= '0;
            r_mainCtrl  <= '0;
            r_skidData  <= '0;
            r_skidCtrl  <= '0;
        end else begin
            r_inReady   <= (w_nextState != FULL);
            r_outValid  <= (w_nextState != EMPTY);
            r_occupancy <= w_nextState;
            r_mainData  <= w_mainDataNext;
            r_mainCtrl  <= w_mainCtrlNext;
            r_skidData  <= w_skidDataNext;
            r_skidCtrl  <= w_skidCtrlNext;
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign out_data  = r_mainData;
    assign out_ctrl  = r_mainCtrl;
    assign occupancy = r_occupancy;

`ifdef PIPE_STAGE_REG_STALL_CNT_EN
    logic [15:0] r_stallCnt;

    // Saturating count of cycles the head is held by downstream; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stallCnt <= 16'd0;
        end else if (r_outValid && !out_ready && (r_stallCnt != 16'hFFFF)) begin
            r_stallCnt <= r_stallCnt + 16'd1;
        end
    end

    assign stall_cnt = r_stallCnt;
`endif

endmodule
